// File: rtl/axis_pkg.sv
// Shared types and defaults for the AXI-Stream packet generator.
//   gen_state_e : generator FSM states
//   cfg_t       : unpacked view of config_packet = {k, len}
package axis_pkg;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_NW = 16;

    typedef enum logic [0:0] {IDLE, SEND} gen_state_e;

    typedef struct packed {
        logic [DEF_DW-1:0] k;
        logic [DEF_DW-1:0] len;
    } cfg_t;

endpackage

// File: rtl/axis_packet_gen_if.sv
// 8-bit AXI-Stream link carrying generated packets.
//   tdata  : stream data        (master -> slave)
//   tvalid : beat valid         (master -> slave)
//   tlast  : last byte of packet (master -> slave)
//   tready : downstream ready   (slave -> master)
interface axis_packet_gen_if
    import axis_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
);

    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_packet_gen.sv
// AXI-Stream packet source. Each run emits npkt packets (0 = until stop) of len bytes
// (len 0 = 2^DW bytes); byte i of packet p is (p + i*k) mod 2^DW.
//   clk, rst      : clock, asynchronous active-high reset
//   config_packet : {k, len}, latched on an accepted start
//   start, stop   : begin a run / end it after the current packet
//   npkt          : packets per run, 0 = continuous
//   m             : stream master (tdata, tvalid, tlast, tready)
//   busy, done    : run in progress / one-cycle end-of-run pulse
//   pkt_cnt       : packets completed in the current or last run
module axis_packet_gen
    import axis_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned NW = DEF_NW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*DW-1:0]     config_packet,
    input  logic                start,
    input  logic                stop,
    input  logic [NW-1:0]       npkt,
    axis_packet_gen_if.master   m,
    output logic                busy,
    output logic                done,
    output logic [NW-1:0]       pkt_cnt
);

    gen_state_e    state_q, state_d;
    logic          stop_q, stop_d;
    logic          done_q, done_d;

    logic [DW-1:0] k_q, k_d;
    logic [DW-1:0] len_q, len_d;
    logic [NW-1:0] npkt_q, npkt_d;
    logic [NW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [DW-1:0] byte_idx_q, byte_idx_d;

    // tdata_q doubles as the pattern accumulator.
    logic [DW-1:0] tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;

    logic [DW-1:0] cfg_k, cfg_len;
    logic          accept, beat, run_end;
    logic [NW-1:0] pkt_next;

    assign cfg_k    = config_packet[2*DW-1:DW];
    assign cfg_len  = config_packet[DW-1:0];
    assign accept   = (state_q == IDLE) && start;
    assign beat     = tvalid_q && m.tready;
    assign pkt_next = pkt_cnt_q + NW'(1);
    // Same-cycle stop counts as pending so the run ends on this tlast.
    assign run_end  = beat && tlast_q &&
                      (((npkt_q != '0) && (pkt_next == npkt_q)) || stop_q || stop);

    // FSM and flags
    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    stop_d  = 1'b0;
                end
            end
            SEND: begin
                if (stop) stop_d = 1'b1;
                if (run_end) begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

    // Latched config and byte/packet counters
    always_comb begin
        k_d        = k_q;
        len_d      = len_q;
        npkt_d     = npkt_q;
        pkt_cnt_d  = pkt_cnt_q;
        byte_idx_d = byte_idx_q;
        if (accept) begin
            k_d        = cfg_k;
            len_d      = cfg_len;
            npkt_d     = npkt;
            pkt_cnt_d  = '0;
            byte_idx_d = '0;
        end else if (beat) begin
            if (tlast_q) begin
                pkt_cnt_d  = pkt_next;
                byte_idx_d = '0;
            end else begin
                byte_idx_d = byte_idx_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q        <= '0;
            len_q      <= '0;
            npkt_q     <= '0;
            pkt_cnt_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            k_q        <= k_d;
            len_q      <= len_d;
            npkt_q     <= npkt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // Output register: only advances on a handshake, so data/last hold under backpressure.
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (accept) begin
            tvalid_d = 1'b1;
            tdata_d  = '0;
            tlast_d  = (cfg_len == DW'(1));
        end else if (beat) begin
            if (run_end) begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tdata_d  = '0;
            end else if (tlast_q) begin
                tdata_d = DW'(pkt_next);
                tlast_d = (len_q == DW'(1));
            end else begin
                tdata_d = tdata_q + k_q;
                // Next index idx+1 is last when idx+1 == len-1; len 0 wraps to 2^DW bytes.
                tlast_d = ((byte_idx_q + DW'(2)) == len_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign m.tdata  = tdata_q;
    assign m.tvalid = tvalid_q;
    assign m.tlast  = tlast_q;
    assign busy     = (state_q == SEND);
    assign done     = done_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
module tb_axis_packet_gen;
    import axis_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned NW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*DW-1:0] config_packet;
    logic          start, stop;
    logic [NW-1:0] npkt;
    logic          busy, done;
    logic [NW-1:0] pkt_cnt;

    axis_packet_gen_if #(.DW(DW)) s_if ();

    axis_packet_gen #(.DW(DW), .NW(NW)) dut (
        .clk           (clk),
        .rst           (rst),
        .config_packet (config_packet),
        .start         (start),
        .stop          (stop),
        .npkt          (npkt),
        .m             (s_if),
        .busy          (busy),
        .done          (done),
        .pkt_cnt       (pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       fin;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    hs_count = 0;
    int    done_count = 0;
    int    first_hs = 0;
    int    last_hs = 0;
    int    cyc = 0;
    bit    rnd_ready = 0;
    bit    done_expect = 0;
    bit    hold_prev = 0;
    logic [7:0] prev_data;
    logic  prev_last;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference model: packet p byte i = (p + i*k) mod 256, len 0 -> 256 bytes.
    task automatic push_run(input int k, input int len, input int pkts);
        int n;
        beat_t b;
        n = (len == 0) ? 256 : len;
        for (int p = 0; p < pkts; p++) begin
            for (int i = 0; i < n; i++) begin
                b.data = 8'((p + i * k) % 256);
                b.last = (i == n - 1);
                b.fin  = (i == n - 1) && (p == pkts - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        s_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_prev   = 0;
            done_expect = 0;
        end else begin
            if (done_expect) begin
                chk("done_after_final", {31'd0, done}, 32'd1);
                chk("busy_low_at_done", {31'd0, busy}, 32'd0);
                done_expect = 0;
            end
            if (done) done_count++;
            if (hold_prev) begin
                chk("hold_tvalid", {31'd0, s_if.tvalid}, 32'd1);
                chk("hold_tdata", {24'd0, s_if.tdata}, {24'd0, prev_data});
                chk("hold_tlast", {31'd0, s_if.tlast}, {31'd0, prev_last});
            end
            hold_prev = s_if.tvalid && !s_if.tready;
            prev_data = s_if.tdata;
            prev_last = s_if.tlast;
            if (s_if.tvalid && s_if.tready) begin
                hs_count++;
                if (hs_count == 1) first_hs = cyc;
                last_hs = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {24'd0, s_if.tdata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", {24'd0, s_if.tdata}, {24'd0, e.data});
                    chk("tlast", {31'd0, s_if.tlast}, {31'd0, e.last});
                    if (e.fin) done_expect = 1;
                end
            end
        end
    end

    task automatic do_start(input int k, input int len, input int pkts, input logic st);
        cfg_t c;
        @(posedge clk);
        #1;
        hs_count   = 0;
        done_count = 0;
        c.k   = 8'(k);
        c.len = 8'(len);
        config_packet = c;
        npkt  = NW'(pkts);
        start = 1'b1;
        stop  = st;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        chk("start_latency_tvalid", {31'd0, s_if.tvalid}, 32'd1);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_pkt_cnt_clear", {16'd0, pkt_cnt}, 32'd0);
    endtask

    task automatic wait_run(input int limit);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("run_in_time", {31'd0, (c < limit)}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_run", {31'd0, busy}, 32'd0);
        chk("done_once", 32'(done_count), 32'd1);
        if (c >= limit) exp_q.delete();
    endtask

    task automatic wait_hs(input int n, input int limit);
        int c = 0;
        while (hs_count < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("beats_reached", {31'd0, (c < limit)}, 32'd1);
    endtask

    initial begin
        int k, len, pk;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        npkt = '0;
        config_packet = '0;
        #7;
        chk("rst_tvalid", {31'd0, s_if.tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, s_if.tlast}, 32'd0);
        chk("rst_tdata", {24'd0, s_if.tdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single packet, continuous ready
        push_run(3, 64, 1);
        do_start(3, 64, 1, 1'b0);
        wait_run(400);
        chk("t1_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
        chk("t1_no_gaps", 32'(last_hs - first_hs + 1), 32'd64);

        // Three back-to-back packets
        push_run(5, 60, 3);
        do_start(5, 60, 3, 1'b0);
        wait_run(600);
        chk("t2_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
        chk("t2_no_gaps", 32'(last_hs - first_hs + 1), 32'd180);

        // Random backpressure
        rnd_ready = 1;
        push_run(3, 64, 2);
        do_start(3, 64, 2, 1'b0);
        wait_run(2000);
        chk("t3_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
        rnd_ready = 0;

        // len 0 = 256 bytes
        push_run(1, 0, 1);
        do_start(1, 0, 1, 1'b0);
        wait_run(800);
        chk("t4_beats", 32'(hs_count), 32'd256);

        // Start and stop together in idle: stop ignored, both packets sent
        push_run(1, 4, 2);
        do_start(1, 4, 2, 1'b1);
        wait_run(200);
        chk("start_stop_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);

        // Continuous mode ended by stop mid-packet 1; a start during the run is ignored
        push_run(2, 10, 2);
        do_start(2, 10, 0, 1'b0);
        wait_hs(15, 100);
        @(posedge clk);
        #1;
        stop = 1'b1;
        start = 1'b1;
        config_packet = {8'd9, 8'd3};
        npkt = NW'(1);
        @(posedge clk);
        #1;
        stop = 1'b0;
        start = 1'b0;
        wait_run(200);
        chk("t5_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
        chk("t5_beats", 32'(hs_count), 32'd20);

        // Asynchronous reset mid-packet
        push_run(4, 50, 1);
        do_start(4, 50, 1, 1'b0);
        wait_hs(10, 100);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_tvalid", {31'd0, s_if.tvalid}, 32'd0);
        chk("arst_tlast", {31'd0, s_if.tlast}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_run(7, 5, 1);
        do_start(7, 5, 1, 1'b0);
        wait_run(100);
        chk("t6_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

        // Randomized runs with random backpressure
        rnd_ready = 1;
        for (int r = 0; r < 5; r++) begin
            k   = int'($urandom_range(0, 255));
            len = (r == 4) ? 0 : int'($urandom_range(1, 20));
            pk  = int'($urandom_range(1, 4));
            push_run(k, len, pk);
            do_start(k, len, pk, 1'b0);
            wait_run(5000);
            chk("rand_pkt_cnt", {16'd0, pkt_cnt}, 32'(pk));
        end
        rnd_ready = 0;

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
